rx_scanner: RTL and testbench
=============================

Name: rx_scanner

Overview:
- Receive-side token scanner for the serial debug unit.
- Sits between the UART receiver's byte stream (d_rx/vld_rx/rdy_rx) and the debug controller's scan request port.
- On request it returns either one command character, or one hex number parsed from ASCII into 32 bits.
- Also reports whether the token ended the command line.

Parameters:
- DATA_W, 32, width of the parsed hex value on din_rx.
- MAX_DIGITS, 8, hex digits that fit in DATA_W. Any further digits raise err_rx.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- d_rx  in  8  received ASCII byte from the UART receiver
- vld_rx  in  1  d_rx valid
- rdy_rx  out  1  scanner accepts a byte this cycle
- req_rx  in  1  scan request from the controller; held high until ack is seen
- type_rx  in  1  0 = character token, 1 = hex token; sampled with req_rx in IDLE
- ack_rx  out  1  one-cycle pulse: token complete, din_rx/flag_rx/err_rx valid
- din_rx  out  DATA_W  char mode: {24'b0, byte}; hex mode: parsed value
- flag_rx  out  1  1 = token terminated by CR or LF (end of line); 0 = terminated by space
- err_rx  out  1  1 = invalid character or digit overflow in hex token

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk.
  - All outputs reset to 0; state goes to IDLE; accumulator and digit count are cleared.
- Byte transfer: a byte is accepted in any cycle where vld_rx && rdy_rx.
  - rdy_rx is combinational: 1 only in CHAR or HEX state.
- States:
  - IDLE:
    - req_rx=1 and type_rx=0 -> CHAR.
    - req_rx=1 and type_rx=1 -> HEX; clear accumulator, digit count and err.
  - CHAR:
    - Accepted 0x20, 0x0D and 0x0A are skipped.
    - Any other accepted byte: din_rx <= {24'b0, byte}, flag_rx <= 0, then -> ACK.
    - No case conversion; 'D' and 'd' are distinct.
  - HEX, per accepted byte:
    - Space, CR or LF while digit count = 0 and byte = space: skipped (leading blanks).
    - '0'-'9', 'a'-'f' or 'A'-'F': acc <= {acc[DATA_W-5:0], nibble}; count++.
      - If count is already MAX_DIGITS, the digit is still shifted in (oldest nibble lost) and err is set.
    - Space with count > 0: -> ACK with flag_rx=0.
    - CR or LF (any count): -> ACK with flag_rx=1. An empty token returns din_rx=0.
    - Any other byte: err set, -> ACK with flag_rx=0, din_rx=acc so far.
  - ACK:
    - ack_rx=1 for exactly this one cycle.
    - din_rx, flag_rx and err_rx are registered and stay stable until the next transaction's ACK.
    - -> DONE.
  - DONE:
    - Waits for req_rx=0, then -> IDLE.
    - A request held high after ack therefore never starts a second scan.
- Latency: ack_rx is asserted the cycle after the terminating byte is accepted.
- Abort: req_rx dropping in CHAR or HEX -> IDLE.
  - No ack; outputs keep their previous values; bytes already consumed are lost.
- vld_rx while not in CHAR or HEX: the byte is not accepted (rdy_rx=0); the upstream holds it.
- Simultaneous events: req_rx and vld_rx in the same IDLE cycle: the byte is not consumed until the next cycle (in CHAR or HEX).
- Reset mid-transaction: immediate return to IDLE, outputs cleared, no ack.

Decomposition:
- Shared package dcp_pkg:
  - ASCII constants (SPACE 8'h20, CR 8'h0D, LF 8'h0A).
  - Scanner state encoding.
  - Token type constants (TYPE_CHAR=0, TYPE_HEX=1).
- One combinational sub-module, ascii_hex_decode:
  - Input: byte.
  - Outputs: nibble[3:0], is_digit, is_term, is_eol.
  - Instantiated once inside rx_scanner.

Test Plan:
- Char: req type 0, bytes 0x20 0x44 -> rdy high, space skipped; ack one cycle after 'D'; din_rx=32'h0000_0044, flag_rx=0, err_rx=0.
- Hex: req type 1, "  1a2B 3" -> ack after the space; din_rx=32'h0000_1A2B, flag_rx=0; the byte '3' is left unaccepted (rdy_rx=0 in DONE).
- Overflow and EOL:
  - "123456789\r" -> din_rx=32'h2345_6789, err_rx=1, flag_rx=1.
  - A lone "\r" -> din_rx=0, flag_rx=1, err_rx=0.
- Invalid char: "12G" -> ack immediately after 'G'; din_rx=32'h12, err_rx=1.
- Handshake: req held high 10 cycles past ack -> exactly one ack; the next ack only after req goes low then high again.
- Abort and reset:
  - req dropped after "12" -> no ack, next scan starts from empty.
  - rst asserted mid-HEX -> all outputs 0 and state IDLE within the same cycle.

Source files
------------

// File: rtl/dcp_pkg.sv
// Shared definitions for the serial debug unit.
//   - ASCII codes the receive scanner treats as token delimiters
//   - scanner state encoding
//   - token type codes carried on type_rx
package dcp_pkg;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  localparam logic TYPE_CHAR = 1'b0;
  localparam logic TYPE_HEX  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CHAR = 3'd1,
    ST_HEX  = 3'd2,
    ST_ACK  = 3'd3,
    ST_DONE = 3'd4
  } scan_state_t;

endpackage

// File: rtl/ascii_hex_decode.sv
// Combinational classifier for one received ASCII byte.
// Ports:
//   data     in  8  ASCII byte
//   nibble   out 4  hex value of the byte (valid when is_digit)
//   is_digit out 1  byte is 0-9, a-f or A-F
//   is_term  out 1  byte is space, CR or LF
//   is_eol   out 1  byte is CR or LF
module ascii_hex_decode
  import dcp_pkg::*;
(
  input  logic [7:0] data,
  output logic [3:0] nibble,
  output logic       is_digit,
  output logic       is_term,
  output logic       is_eol
);

  logic is_dec;
  logic is_alpha;

  assign is_dec   = (data >= 8'h30) && (data <= 8'h39);
  // Upper and lower case letters differ only in bit 5.
  assign is_alpha = ((data >= 8'h41) && (data <= 8'h46)) ||
                    ((data >= 8'h61) && (data <= 8'h66));

  assign is_digit = is_dec || is_alpha;
  // 'A'/'a' have low nibble 1, so adding 9 yields 10..15.
  assign nibble   = is_alpha ? (data[3:0] + 4'd9) : data[3:0];

  assign is_eol  = (data == ASCII_CR) || (data == ASCII_LF);
  assign is_term = is_eol || (data == ASCII_SPACE);

endmodule

// File: rtl/rx_scanner.sv
// Receive-side token scanner: on each request pulls bytes from the UART
// receiver and returns one command character or one parsed hex number.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   d_rx, vld_rx        received byte and its valid
//   rdy_rx              byte accepted this cycle when vld_rx is also high
//   req_rx, type_rx     scan request (held until ack) and token type
//   ack_rx              one-cycle completion pulse
//   din_rx, flag_rx,    token value, end-of-line flag, error flag;
//   err_rx              held until the next completed token
module rx_scanner
  import dcp_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int MAX_DIGITS = 8
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        d_rx,
  input  logic              vld_rx,
  output logic              rdy_rx,
  input  logic              req_rx,
  input  logic              type_rx,
  output logic              ack_rx,
  output logic [DATA_W-1:0] din_rx,
  output logic              flag_rx,
  output logic              err_rx
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  scan_state_t       state_reg, state_next;
  logic [DATA_W-1:0] acc_reg, acc_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              err_reg, err_next;
  logic [DATA_W-1:0] din_reg, din_next;
  logic              flag_reg, flag_next;
  logic              err_out_reg, err_out_next;

  logic [3:0] nibble;
  logic       is_digit;
  logic       is_term;
  logic       is_eol;
  logic       accept;

  ascii_hex_decode u_decode (
    .data     (d_rx),
    .nibble   (nibble),
    .is_digit (is_digit),
    .is_term  (is_term),
    .is_eol   (is_eol)
  );

  assign rdy_rx  = (state_reg == ST_CHAR) || (state_reg == ST_HEX);
  assign accept  = vld_rx && rdy_rx;
  assign ack_rx  = (state_reg == ST_ACK);
  assign din_rx  = din_reg;
  assign flag_rx = flag_reg;
  assign err_rx  = err_out_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      acc_reg     <= '0;
      cnt_reg     <= '0;
      err_reg     <= 1'b0;
      din_reg     <= '0;
      flag_reg    <= 1'b0;
      err_out_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      acc_reg     <= acc_next;
      cnt_reg     <= cnt_next;
      err_reg     <= err_next;
      din_reg     <= din_next;
      flag_reg    <= flag_next;
      err_out_reg <= err_out_next;
    end
  end

  // Result registers only change on the transition into ST_ACK, so an
  // aborted scan leaves the previous token's result visible.
  always_comb begin
    state_next   = state_reg;
    acc_next     = acc_reg;
    cnt_next     = cnt_reg;
    err_next     = err_reg;
    din_next     = din_reg;
    flag_next    = flag_reg;
    err_out_next = err_out_reg;

    case (state_reg)
      ST_IDLE: begin
        if (req_rx) begin
          if (type_rx == TYPE_HEX) begin
            state_next = ST_HEX;
            acc_next   = '0;
            cnt_next   = '0;
            err_next   = 1'b0;
          end else begin
            state_next = ST_CHAR;
          end
        end
      end

      ST_CHAR: begin
        if (!req_rx) begin
          state_next = ST_IDLE;
        end else if (accept && !is_term) begin
          din_next      = '0;
          din_next[7:0] = d_rx;
          flag_next     = 1'b0;
          err_out_next  = 1'b0;
          state_next    = ST_ACK;
        end
      end

      ST_HEX: begin
        if (!req_rx) begin
          state_next = ST_IDLE;
        end else if (accept) begin
          if (is_digit) begin
            // Past MAX_DIGITS keep shifting (oldest nibble drops out) but
            // hold the count so it cannot wrap.
            acc_next = {acc_reg[DATA_W-5:0], nibble};
            if (cnt_reg == CNT_W'(MAX_DIGITS)) begin
              err_next = 1'b1;
            end else begin
              cnt_next = cnt_reg + CNT_W'(1);
            end
          end else if (is_eol) begin
            din_next     = acc_reg;
            flag_next    = 1'b1;
            err_out_next = err_reg;
            state_next   = ST_ACK;
          end else if (is_term) begin
            // Leading spaces are skipped; a space after digits ends the token.
            if (cnt_reg != '0) begin
              din_next     = acc_reg;
              flag_next    = 1'b0;
              err_out_next = err_reg;
              state_next   = ST_ACK;
            end
          end else begin
            err_next     = 1'b1;
            din_next     = acc_reg;
            flag_next    = 1'b0;
            err_out_next = 1'b1;
            state_next   = ST_ACK;
          end
        end
      end

      ST_ACK: begin
        state_next = ST_DONE;
      end

      ST_DONE: begin
        if (!req_rx) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rx_scanner.sv
module tb_rx_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  d_rx;
  logic        vld_rx;
  logic        rdy_rx;
  logic        req_rx;
  logic        type_rx;
  logic        ack_rx;
  logic [31:0] din_rx;
  logic        flag_rx;
  logic        err_rx;

  int checks = 0;
  int failures = 0;
  int ack_cnt = 0;

  typedef struct packed {
    logic [31:0] din;
    logic        flag;
    logic        err;
  } res_t;

  res_t exp_q[$];
  res_t act_q[$];

  rx_scanner #(.DATA_W(32), .MAX_DIGITS(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .d_rx    (d_rx),
    .vld_rx  (vld_rx),
    .rdy_rx  (rdy_rx),
    .req_rx  (req_rx),
    .type_rx (type_rx),
    .ack_rx  (ack_rx),
    .din_rx  (din_rx),
    .flag_rx (flag_rx),
    .err_rx  (err_rx)
  );

  always #5 clk = ~clk;

  // Capture every completed token on the falling edge.
  always @(negedge clk) begin
    if (ack_rx) begin
      act_q.push_back('{din: din_rx, flag: flag_rx, err: err_rx});
      ack_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // All driving happens at the falling edge; a byte is taken on the next
  // rising edge if rdy_rx is high now.
  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    d_rx = b;
    vld_rx = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (rdy_rx) ok = 1'b1;
      @(negedge clk);
    end
    vld_rx = 1'b0;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send_byte timeout byte=%h rdy_rx=%b required 1", b, rdy_rx);
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic start_scan(input logic t);
    req_rx = 1'b1;
    type_rx = t;
  endtask

  task automatic end_scan();
    req_rx = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({ack_rx, rdy_rx, flag_rx, err_rx} !== 4'b0) begin
      failures++;
      $display("FAIL reset_ctl ack=%b rdy=%b flag=%b err=%b required all 0", ack_rx, rdy_rx, flag_rx, err_rx);
    end
    checks++;
    if (din_rx !== 32'h0) begin
      failures++;
      $display("FAIL reset_din din=%h required 00000000", din_rx);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_char();
    res_t r, e;
    exp_q.push_back('{din: 32'h0000_0044, flag: 1'b0, err: 1'b0});
    start_scan(1'b0);
    send_byte(8'h20);
    send_byte(8'h44);
    checks++;
    if (ack_rx !== 1'b1) begin
      failures++;
      $display("FAIL char_latency ack=%b required 1", ack_rx);
    end
    end_scan();
    e = exp_q.pop_front();
    checks++;
    if (act_q.size() == 0) begin
      failures++;
      $display("FAIL char_result no ack required din=%h", e.din);
    end else begin
      r = act_q.pop_front();
      $display("txn char din=%h flag=%b err=%b", r.din, r.flag, r.err);
      if (r !== e) begin
        failures++;
        $display("FAIL char_result din=%h flag=%b err=%b required din=%h flag=%b err=%b", r.din, r.flag, r.err, e.din, e.flag, e.err);
      end
    end
  endtask

  task automatic test_hex();
    res_t r, e;
    bit seen_rdy;
    exp_q.push_back('{din: 32'h0000_1A2B, flag: 1'b0, err: 1'b0});
    start_scan(1'b1);
    send_str("  1a2B ");
    checks++;
    if (ack_rx !== 1'b1) begin
      failures++;
      $display("FAIL hex_latency ack=%b required 1", ack_rx);
    end
    // Next byte must be held off while the request is still high.
    seen_rdy = 1'b0;
    d_rx = 8'h33;
    vld_rx = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (rdy_rx) seen_rdy = 1'b1;
      @(negedge clk);
    end
    vld_rx = 1'b0;
    checks++;
    if (seen_rdy) begin
      failures++;
      $display("FAIL hex_hold rdy_rx went 1 after ack required 0");
    end
    end_scan();
    e = exp_q.pop_front();
    checks++;
    if (act_q.size() == 0) begin
      failures++;
      $display("FAIL hex_result no ack required din=%h", e.din);
    end else begin
      r = act_q.pop_front();
      $display("txn hex din=%h flag=%b err=%b", r.din, r.flag, r.err);
      if (r !== e) begin
        failures++;
        $display("FAIL hex_result din=%h flag=%b err=%b required din=%h flag=%b err=%b", r.din, r.flag, r.err, e.din, e.flag, e.err);
      end
    end
  endtask

  task automatic test_overflow_eol();
    res_t r, e;
    exp_q.push_back('{din: 32'h2345_6789, flag: 1'b1, err: 1'b1});
    exp_q.push_back('{din: 32'h0000_0000, flag: 1'b1, err: 1'b0});
    start_scan(1'b1);
    send_str("123456789");
    send_byte(8'h0D);
    end_scan();
    start_scan(1'b1);
    send_byte(8'h0D);
    end_scan();
    for (int k = 0; k < 2; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (act_q.size() == 0) begin
        failures++;
        $display("FAIL overflow_eol_%0d no ack required din=%h", k, e.din);
      end else begin
        r = act_q.pop_front();
        $display("txn overflow_eol_%0d din=%h flag=%b err=%b", k, r.din, r.flag, r.err);
        if (r !== e) begin
          failures++;
          $display("FAIL overflow_eol_%0d din=%h flag=%b err=%b required din=%h flag=%b err=%b", k, r.din, r.flag, r.err, e.din, e.flag, e.err);
        end
      end
    end
  endtask

  task automatic test_invalid();
    res_t r, e;
    exp_q.push_back('{din: 32'h0000_0012, flag: 1'b0, err: 1'b1});
    start_scan(1'b1);
    send_str("12G");
    checks++;
    if (ack_rx !== 1'b1) begin
      failures++;
      $display("FAIL invalid_latency ack=%b required 1", ack_rx);
    end
    end_scan();
    e = exp_q.pop_front();
    checks++;
    if (act_q.size() == 0) begin
      failures++;
      $display("FAIL invalid_result no ack required din=%h", e.din);
    end else begin
      r = act_q.pop_front();
      $display("txn invalid din=%h flag=%b err=%b", r.din, r.flag, r.err);
      if (r !== e) begin
        failures++;
        $display("FAIL invalid_result din=%h flag=%b err=%b required din=%h flag=%b err=%b", r.din, r.flag, r.err, e.din, e.flag, e.err);
      end
    end
  endtask

  task automatic test_back_to_back();
    res_t r, e;
    int base;
    exp_q.push_back('{din: 32'h0000_0064, flag: 1'b0, err: 1'b0});
    exp_q.push_back('{din: 32'h0000_0044, flag: 1'b0, err: 1'b0});
    base = ack_cnt;
    start_scan(1'b0);
    send_byte(8'h64);
    d_rx = 8'h44;
    vld_rx = 1'b1;
    repeat (10) @(negedge clk);
    vld_rx = 1'b0;
    checks++;
    if (ack_cnt - base !== 1) begin
      failures++;
      $display("FAIL held_req acks=%0d required 1", ack_cnt - base);
    end
    end_scan();
    start_scan(1'b0);
    send_byte(8'h44);
    end_scan();
    checks++;
    if (ack_cnt - base !== 2) begin
      failures++;
      $display("FAIL rerequest acks=%0d required 2", ack_cnt - base);
    end
    for (int k = 0; k < 2; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (act_q.size() == 0) begin
        failures++;
        $display("FAIL b2b_%0d no ack required din=%h", k, e.din);
      end else begin
        r = act_q.pop_front();
        $display("txn b2b_%0d din=%h flag=%b err=%b", k, r.din, r.flag, r.err);
        if (r !== e) begin
          failures++;
          $display("FAIL b2b_%0d din=%h flag=%b err=%b required din=%h flag=%b err=%b", k, r.din, r.flag, r.err, e.din, e.flag, e.err);
        end
      end
    end
  endtask

  task automatic test_abort();
    res_t r, e;
    int base;
    base = ack_cnt;
    start_scan(1'b1);
    send_str("12");
    end_scan();
    checks++;
    if (ack_cnt !== base || din_rx !== 32'h0000_0044) begin
      failures++;
      $display("FAIL abort acks=%0d din=%h required acks=0 din=00000044", ack_cnt - base, din_rx);
    end
    exp_q.push_back('{din: 32'h0000_0005, flag: 1'b1, err: 1'b0});
    start_scan(1'b1);
    send_byte(8'h35);
    send_byte(8'h0A);
    end_scan();
    e = exp_q.pop_front();
    checks++;
    if (act_q.size() == 0) begin
      failures++;
      $display("FAIL abort_next no ack required din=%h", e.din);
    end else begin
      r = act_q.pop_front();
      $display("txn abort_next din=%h flag=%b err=%b", r.din, r.flag, r.err);
      if (r !== e) begin
        failures++;
        $display("FAIL abort_next din=%h flag=%b err=%b required din=%h flag=%b err=%b", r.din, r.flag, r.err, e.din, e.flag, e.err);
      end
    end
  endtask

  task automatic test_reset_mid();
    start_scan(1'b1);
    send_str("12");
    rst = 1'b1;
    #1;
    checks++;
    if ({ack_rx, rdy_rx, flag_rx, err_rx} !== 4'b0 || din_rx !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid ack=%b rdy=%b din=%h flag=%b err=%b required all 0", ack_rx, rdy_rx, din_rx, flag_rx, err_rx);
    end
    @(negedge clk);
    req_rx = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    d_rx = 8'h00;
    vld_rx = 1'b0;
    req_rx = 1'b0;
    type_rx = 1'b0;
    @(negedge clk);
    test_reset();
    test_char();
    test_hex();
    test_overflow_eol();
    test_invalid();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0 || act_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover expected=%0d observed=%0d required 0 0", exp_q.size(), act_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
